layer_shift_driver: RTL and testbench

- Serialises one layer's column-data word into the cube's daisy-chained LED shift registers, then pulses latch so the outputs update.
- Sits directly downstream of the free-running layer scan counter: each counter step selects a new layer, the frame buffer presents that layer's word here, and this block shifts it out.
- Generates sclk, sdata, latch and blank for the LED driver chain; the valid/ready input handshake throttles the upstream scan.

---
 rtl/layer_drv_pkg.sv | 16 +
 rtl/layer_shift_driver_phase_timer.sv | 27 ++
 rtl/layer_shift_driver.sv | 152 +++++++++++++++
 tb/tb_layer_shift_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_drv_pkg.sv
// Shared types and helpers for the LED layer shift driver.
// Holds the FSM state encoding and the counter-width helper.
package layer_drv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/layer_shift_driver_phase_timer.sv
// Loadable down-counter: load the phase length, o_tc is high in the phase's last cycle.
// Latency: o_tc asserts i_load_val cycles after the load edge; no backpressure.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/layer_shift_driver.sv
// Shifts one layer word into the LED driver chain, then pulses latch.
// One word per 2*DIV*DATA_W + LATCH_W + 1 cycles; data_ready holds off upstream while busy.
module layer_shift_driver
    import layer_drv_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DIV       = 4,
    parameter int LATCH_W   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              sclk,
    output logic              sdata,
    output logic              latch,
    output logic              blank,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = cnt_w(DATA_W);
    localparam int TMR_W = cnt_w((DIV > LATCH_W) ? DIV : LATCH_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_sclk;
    logic               r_sdata;
    logic               r_latch;
    logic               r_blank;
    logic               r_done;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tc;
    logic               w_accept;
    logic               w_bit_end;
    logic               w_last_bit;
    logic               w_next_bit;

    phase_timer #(.W(TMR_W)) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tc)
    );

    assign w_accept   = data_valid && (r_state == IDLE);
    assign w_bit_end  = (r_state == SHIFT_HI) && w_tc;
    assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = TMR_W'(DIV);
        case (r_state)
            IDLE: begin
                if (data_valid) begin
                    w_state_nxt = SHIFT_LO;
                    w_tmr_load  = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (w_tc) begin
                    w_state_nxt = SHIFT_HI;
                    w_tmr_load  = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (w_tc) begin
                    w_tmr_load = 1'b1;
                    if (w_last_bit) begin
                        w_state_nxt = LATCH;
                        w_tmr_val   = TMR_W'(LATCH_W);
                    end else begin
                        w_state_nxt = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (w_tc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = data_in;
        end else if (w_bit_end) begin
            w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
        end
        w_next_bit = (MSB_FIRST != 0) ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_latch   <= 1'b0;
            r_blank   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_accept) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            r_sclk  <= (w_state_nxt == SHIFT_HI);
            r_latch <= (w_state_nxt == LATCH);
            if (w_state_nxt == SHIFT_LO) begin
                r_sdata <= w_next_bit;
            end
            r_done <= (r_state == LATCH) && w_tc;
            // Outputs go live only once a complete word has been latched.
            if (w_state_nxt == LATCH) begin
                r_blank <= 1'b1;
            end else if ((r_state == LATCH) && w_tc) begin
                r_blank <= 1'b0;
            end
        end
    end

    assign data_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign sclk       = r_sclk;
    assign sdata      = r_sdata;
    assign latch      = r_latch;
    assign blank      = r_blank;
    assign done       = r_done;

endmodule

// File: tb/tb_layer_shift_driver.sv
// Directed bench for layer_shift_driver in three configurations, with a bit scoreboard per instance.
module tb_layer_shift_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // a: DATA_W=8 DIV=2 LATCH_W=2 MSB first; b: same LSB first; c: DATA_W=2 DIV=1 LATCH_W=1
    logic [7:0] dat_a = '0, dat_b = '0;
    logic [1:0] dat_c = '0;
    logic vld_a = 0, vld_b = 0, vld_c = 0;
    logic rdy_a, sclk_a, sdata_a, latch_a, blank_a, busy_a, done_a;
    logic rdy_b, sclk_b, sdata_b, latch_b, blank_b, busy_b, done_b;
    logic rdy_c, sclk_c, sdata_c, latch_c, blank_c, busy_c, done_c;

    layer_shift_driver #(.DATA_W(8), .DIV(2), .LATCH_W(2), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(dat_a), .data_valid(vld_a), .data_ready(rdy_a),
        .sclk(sclk_a), .sdata(sdata_a), .latch(latch_a), .blank(blank_a), .busy(busy_a), .done(done_a));
    layer_shift_driver #(.DATA_W(8), .DIV(2), .LATCH_W(2), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .data_in(dat_b), .data_valid(vld_b), .data_ready(rdy_b),
        .sclk(sclk_b), .sdata(sdata_b), .latch(latch_b), .blank(blank_b), .busy(busy_b), .done(done_b));
    layer_shift_driver #(.DATA_W(2), .DIV(1), .LATCH_W(1), .MSB_FIRST(1)) dut_c (
        .clk(clk), .reset(reset), .data_in(dat_c), .data_valid(vld_c), .data_ready(rdy_c),
        .sclk(sclk_c), .sdata(sdata_c), .latch(latch_c), .blank(blank_c), .busy(busy_c), .done(done_c));

    int checks = 0;
    int errors = 0;

    logic q_a[$];
    logic q_b[$];
    logic q_c[$];

    int cyc_a, cyc_b, cyc_c;
    logic psclk_a = 0, psclk_b = 0, psclk_c = 0, platch_a = 0;
    int rise_a, rise_b, rise_c;
    int busy_cnt_a, latch_pulses_a, lat_first_a, lat_last_a, bad_blank_a;
    int overlap, done_cnt_a, done_cyc_a, ready_busy_a;
    int done_cnt_b, lat_cyc_c, done_cyc_c;
    logic [3:0] sc_hist_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rise_a = 0; rise_b = 0; rise_c = 0;
        busy_cnt_a = 0; latch_pulses_a = 0; lat_first_a = -1; lat_last_a = -1;
        bad_blank_a = 0; overlap = 0; done_cnt_a = 0; done_cyc_a = -1; ready_busy_a = 0;
        done_cnt_b = 0; lat_cyc_c = -1; done_cyc_c = -1; sc_hist_c = '0;
    endtask

    // Advance one clock and sample everything 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc_a++; cyc_b++; cyc_c++;
        if (sclk_a && !psclk_a) begin
            rise_a++;
            if (q_a.size() == 0) chk("a_unexpected_rise", q_a.size(), 1);
            else chk("a_bit", sdata_a, q_a.pop_front());
        end
        if (sclk_b && !psclk_b) begin
            rise_b++;
            if (q_b.size() == 0) chk("b_unexpected_rise", q_b.size(), 1);
            else chk("b_bit", sdata_b, q_b.pop_front());
        end
        if (sclk_c && !psclk_c) begin
            rise_c++;
            if (q_c.size() == 0) chk("c_unexpected_rise", q_c.size(), 1);
            else chk("c_bit", sdata_c, q_c.pop_front());
        end
        psclk_a = sclk_a; psclk_b = sclk_b; psclk_c = sclk_c;
        if (busy_a) busy_cnt_a++;
        if (latch_a && !platch_a) latch_pulses_a++;
        platch_a = latch_a;
        if (latch_a) begin
            if (lat_first_a < 0) lat_first_a = cyc_a;
            lat_last_a = cyc_a;
            if (!blank_a) bad_blank_a++;
        end
        if ((latch_a && sclk_a) || (latch_b && sclk_b) || (latch_c && sclk_c)) overlap++;
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc_a; end
        if (busy_a && rdy_a) ready_busy_a++;
        if (done_b) done_cnt_b++;
        if (cyc_c >= 1 && cyc_c <= 4) sc_hist_c[cyc_c-1] = sclk_c;
        if (latch_c) lat_cyc_c = cyc_c;
        if (done_c) done_cyc_c = cyc_c;
    endtask

    initial begin
        int early_unblank;
        logic blank35;
        logic got2;
        int acc2_cyc;
        int blank_high_shift;
        logic [7:0] w;

        clear_stats();
        repeat (3) step();
        chk("rst_sclk", sclk_a, 1'b0);
        chk("rst_sdata", sdata_a, 1'b0);
        chk("rst_latch", latch_a, 1'b0);
        chk("rst_blank", blank_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ready", rdy_a, 1'b1);
        reset = 1'b0;
        step();

        // A5 MSB first
        clear_stats();
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) q_a.push_back(w[i]);
        dat_a = w; vld_a = 1'b1; cyc_a = 0;
        early_unblank = 0; blank35 = 1'bx;
        step();
        vld_a = 1'b0; dat_a = 8'h00;
        for (int i = 0; i < 40; i++) begin
            if (cyc_a < 35 && !blank_a) early_unblank++;
            if (cyc_a == 35) blank35 = blank_a;
            step();
        end
        chk("a5_rises", rise_a, 8);
        chk("a5_queue_left", q_a.size(), 0);
        chk("a5_latch_first", lat_first_a, 33);
        chk("a5_latch_last", lat_last_a, 34);
        chk("a5_latch_pulses", latch_pulses_a, 1);
        chk("a5_done_cycle", done_cyc_a, 35);
        chk("a5_done_count", done_cnt_a, 1);
        chk("a5_busy_cycles", busy_cnt_a, 34);
        chk("a5_blank_before_latch_end", early_unblank, 0);
        chk("a5_blank_in_done", blank35, 1'b0);

        // 01 LSB first
        clear_stats();
        w = 8'h01;
        for (int i = 0; i < 8; i++) q_b.push_back(w[i]);
        dat_b = w; vld_b = 1'b1; cyc_b = 0;
        step();
        vld_b = 1'b0;
        repeat (40) step();
        chk("lsb_rises", rise_b, 8);
        chk("lsb_queue_left", q_b.size(), 0);
        chk("lsb_done_count", done_cnt_b, 1);

        // back-to-back 3C then C3 with valid held high
        clear_stats();
        w = 8'h3C;
        for (int i = 7; i >= 0; i--) q_a.push_back(w[i]);
        dat_a = w; vld_a = 1'b1; cyc_a = 0;
        step();
        w = 8'hC3;
        for (int i = 7; i >= 0; i--) q_a.push_back(w[i]);
        dat_a = w;
        acc2_cyc = -1; blank_high_shift = 0;
        for (int i = 0; i < 90; i++) begin
            got2 = vld_a && rdy_a;
            if (got2) begin
                chk("b2b_accept_in_done", done_a, 1'b1);
                acc2_cyc = cyc_a;
            end
            if (cyc_a > 35 && busy_a && !latch_a && blank_a) blank_high_shift++;
            step();
            if (got2) vld_a = 1'b0;
        end
        vld_a = 1'b0;
        chk("b2b_accept_cycle", acc2_cyc, 35);
        chk("b2b_rises", rise_a, 16);
        chk("b2b_queue_left", q_a.size(), 0);
        chk("b2b_latch_pulses", latch_pulses_a, 2);
        chk("b2b_done_count", done_cnt_a, 2);
        chk("b2b_ready_while_busy", ready_busy_a, 0);
        chk("b2b_blank_in_latch", bad_blank_a, 0);
        chk("b2b_blank_while_shifting", blank_high_shift, 0);
        chk("latch_sclk_overlap", overlap, 0);

        // reset in cycle 10 of a transfer
        clear_stats();
        w = 8'hFF;
        for (int i = 7; i >= 0; i--) q_a.push_back(w[i]);
        dat_a = w; vld_a = 1'b1; cyc_a = 0;
        step();
        vld_a = 1'b0;
        while (cyc_a < 10) step();
        chk("mid_sdata_before_reset", sdata_a, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_sclk", sclk_a, 1'b0);
        chk("mid_sdata", sdata_a, 1'b0);
        chk("mid_latch", latch_a, 1'b0);
        chk("mid_blank", blank_a, 1'b1);
        chk("mid_ready", rdy_a, 1'b1);
        q_a.delete();
        rise_a = 0; done_cnt_a = 0; latch_pulses_a = 0;
        repeat (40) step();
        chk("mid_no_done", done_cnt_a, 0);
        chk("mid_no_rises", rise_a, 0);
        chk("mid_no_latch", latch_pulses_a, 0);
        chk("mid_blank_held", blank_a, 1'b1);

        // DIV=1, LATCH_W=1, DATA_W=2, word 2'b10
        clear_stats();
        q_c.push_back(1'b1);
        q_c.push_back(1'b0);
        dat_c = 2'b10; vld_c = 1'b1; cyc_c = 0;
        step();
        vld_c = 1'b0;
        repeat (10) step();
        chk("c_sclk_pattern", sc_hist_c, 4'b1010);
        chk("c_rises", rise_c, 2);
        chk("c_queue_left", q_c.size(), 0);
        chk("c_latch_cycle", lat_cyc_c, 5);
        chk("c_done_cycle", done_cyc_c, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
